// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and default lockout length for the early debouncer
package debounce_pkg;
   typedef enum logic [1:0] {START = 2'b00, WAIT1 = 2'b01, HOLD = 2'b10, WAIT2 = 2'b11} state_t;
   localparam int LOCK_DEFAULT = 2000000;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one leading-edge debouncer channel; optional input synchroniser under DEBOUNCE_SYNC_EN
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int LOCK_CYCLES = LOCK_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic out,
   output logic rise,
   output logic fall,
   output logic busy
);
   localparam int CNT_W = $clog2(LOCK_CYCLES);
   state_t state;
   logic [CNT_W-1:0] cnt;
   logic samp;
   logic last;
`ifdef DEBOUNCE_SYNC_EN
   logic [1:0] sync;
   // two-flop synchroniser ahead of the FSM for asynchronous pins
   always_ff @(posedge clk) sync <= reset ? 2'b00 : {sync[0], in};
   assign samp = sync[1];
`else
   assign samp = in;
`endif
   assign last = cnt == CNT_W'(LOCK_CYCLES - 1);
   // accept the first edge at once, then ignore the input until the lockout counter expires
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= START;
         cnt   <= '0;
      end else begin
         case (state)
            START: begin
               cnt <= '0;
               if (samp) state <= WAIT1;
            end
            WAIT1: begin
               cnt <= last ? '0 : cnt + 1'b1;
               if (last) state <= HOLD;
            end
            HOLD: begin
               cnt <= '0;
               if (!samp) state <= WAIT2;
            end
            WAIT2: begin
               cnt <= last ? '0 : cnt + 1'b1;
               if (last) state <= START;
            end
            default: begin
               state <= START;
               cnt   <= '0;
            end
         endcase
      end
   end
   // level and strobes decode straight from the registered state and counter
   always_comb begin
      out  = state == WAIT1 || state == HOLD;
      busy = state == WAIT1 || state == WAIT2;
      rise = state == WAIT1 && cnt == '0;
      fall = state == WAIT2 && cnt == '0;
   end
endmodule

// File: rtl/early_debouncer_multi.sv
// early_debouncer_multi: N_CH independent leading-edge debouncers; DEBOUNCE_SYNC_EN adds input synchronisers
module early_debouncer_multi
   import debounce_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int LOCK_CYCLES = LOCK_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] in,
   output logic [N_CH-1:0] out,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic [N_CH-1:0] busy
);
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(.LOCK_CYCLES(LOCK_CYCLES)) u_ch (
         .clk  (clk),
         .reset(reset),
         .in   (in[i]),
         .out  (out[i]),
         .rise (rise[i]),
         .fall (fall[i]),
         .busy (busy[i])
      );
   end
endmodule
